// File: rtl/if_fetch_buffer.sv
// Fetch-to-decode FIFO: tags each fetched {pc, instr} with an address-error flag
// and flushes in one cycle on a redirect. in_ready doubles as the PC stall input.
module if_fetch_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter logic [31:0] PC_LO = 32'h0000_3000,
    parameter logic [31:0] PC_HI = 32'h0000_6ffc
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [31:0]              in_pc,
    input  logic [31:0]              in_instr,
    output logic                     in_ready,
    input  logic                     flush,
    output logic                     out_valid,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_instr,
    output logic                     out_adel,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [31:0]   pc_mem_q    [DEPTH];
    logic [31:0]   instr_mem_q [DEPTH];
    logic          adel_mem_q  [DEPTH];

    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;

    logic          push, pop, in_adel;

    always_comb begin
        // Handshake flags come only from registered count, so out_ready never reaches in_ready.
        in_ready  = (count_q != FULL_CNT);
        out_valid = (count_q != '0);
        push      = in_valid & in_ready & ~flush;
        pop       = out_valid & out_ready & ~flush;
        in_adel   = (in_pc[1:0] != 2'b00) | (in_pc < PC_LO) | (in_pc > PC_HI);

        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;

        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end

        out_pc    = out_valid ? pc_mem_q[rd_ptr_q]    : '0;
        out_instr = out_valid ? instr_mem_q[rd_ptr_q] : '0;
        out_adel  = out_valid ? adel_mem_q[rd_ptr_q]  : 1'b0;
        count     = count_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage is never cleared; a write during reset is invisible once pointers are zeroed.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]    <= in_pc;
            instr_mem_q[wr_ptr_q] <= in_adel ? '0 : in_instr;
            adel_mem_q[wr_ptr_q]  <= in_adel;
        end
    end

endmodule

// File: tb/tb_if_fetch_buffer.sv
// Bench for if_fetch_buffer: directed scenarios plus random traffic checked
// against a queue-based model of the fetch buffer.
module tb_if_fetch_buffer;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, flush, out_valid, out_adel, out_ready;
    logic [31:0] in_pc, in_instr, out_pc, out_instr;
    logic [2:0]  count;

    int checks = 0;
    int passes = 0;

    typedef struct packed {
        logic        adel;
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t mq[$];

    if_fetch_buffer #(.DEPTH(DEPTH), .PC_LO(32'h0000_3000), .PC_HI(32'h0000_6ffc)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
        .in_ready(in_ready), .flush(flush), .out_valid(out_valid), .out_pc(out_pc),
        .out_instr(out_instr), .out_adel(out_adel), .out_ready(out_ready), .count(count)
    );

    always #5 clk = ~clk;

    function automatic logic bad_addr(input logic [31:0] pc);
        return (pc % 4 != 0) || (pc < 32'h3000) || (pc > 32'h6ffc);
    endfunction

    // Drive one cycle of inputs, let the edge happen, advance the model, settle.
    task automatic cycle(input logic iv, input logic [31:0] pc, input logic [31:0] ins,
                         input logic ordy, input logic fl, input logic rst);
        bit can_push, can_pop;
        ent_t e;
        in_valid = iv; in_pc = pc; in_instr = ins; out_ready = ordy; flush = fl; reset = rst;
        @(posedge clk);
        if (rst || fl) begin
            mq.delete();
        end else begin
            can_push = mq.size() < DEPTH;
            can_pop  = (mq.size() > 0) && ordy;
            if (can_pop) void'(mq.pop_front());
            if (iv && can_push) begin
                e.adel  = bad_addr(pc);
                e.pc    = pc;
                e.instr = e.adel ? 32'h0 : ins;
                mq.push_back(e);
            end
        end
        #1;
    endtask

    task automatic test_reset;
        cycle(0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 1);
        checks++; if (count !== 3'd0) $display("FAIL reset_count: got %0d want 0", count); else passes++;
        checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else passes++;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passes++;
        checks++; if ({out_pc, out_instr, out_adel} !== 65'h0)
            $display("FAIL reset_outputs: got pc=%h instr=%h adel=%b want zeros", out_pc, out_instr, out_adel); else passes++;
        cycle(1, 32'h3000, 32'h3c01_0001, 0, 0, 0);
        checks++; if (out_valid !== 1'b1) $display("FAIL basic_valid: got %b want 1", out_valid); else passes++;
        checks++; if (out_pc !== 32'h3000) $display("FAIL basic_pc: got %h want 00003000", out_pc); else passes++;
        checks++; if (out_instr !== 32'h3c01_0001) $display("FAIL basic_instr: got %h want 3c010001", out_instr); else passes++;
        checks++; if (count !== 3'd1) $display("FAIL basic_count: got %0d want 1", count); else passes++;
    endtask

    task automatic test_fill;
        cycle(0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 4; k++) cycle(1, 32'h3000 + 4 * k, 32'h100 + k, 0, 0, 0);
        checks++; if (count !== 3'd4) $display("FAIL fill_count: got %0d want 4", count); else passes++;
        checks++; if (in_ready !== 1'b0) $display("FAIL fill_in_ready: got %b want 0", in_ready); else passes++;
        cycle(1, 32'h3010, 32'h999, 0, 0, 0);
        checks++; if (count !== 3'd4) $display("FAIL fill_fifth_ignored: got count %0d want 4", count); else passes++;
        for (int k = 0; k < 4; k++) begin
            checks++; if (out_pc !== 32'h3000 + 4 * k)
                $display("FAIL fill_pop_order: got %h want %h", out_pc, 32'h3000 + 4 * k); else passes++;
            cycle(0, 0, 0, 1, 0, 0);
        end
        checks++; if (out_valid !== 1'b0 || out_pc !== 32'h0)
            $display("FAIL fill_drained: got valid=%b pc=%h want 0/0", out_valid, out_pc); else passes++;
    endtask

    task automatic test_stream;
        cycle(0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 10; k++) begin
            cycle(1, 32'h3000 + 4 * k, 32'h2000_0000 + k, 1, 0, 0);
            checks++; if (count !== 3'd1) $display("FAIL stream_count k=%0d: got %0d want 1", k, count); else passes++;
            checks++; if (out_pc !== 32'h3000 + 4 * k || out_instr !== 32'h2000_0000 + k)
                $display("FAIL stream_head k=%0d: got %h/%h want %h/%h", k, out_pc, out_instr,
                         32'h3000 + 4 * k, 32'h2000_0000 + k); else passes++;
        end
        cycle(0, 0, 0, 1, 0, 0);
        checks++; if (out_valid !== 1'b0) $display("FAIL stream_drain: got %b want 0", out_valid); else passes++;
    endtask

    task automatic test_full_simul;
        cycle(0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 4; k++) cycle(1, 32'h3000 + 4 * k, k, 0, 0, 0);
        cycle(1, 32'h3010, 32'h55, 1, 0, 0);
        checks++; if (count !== 3'd3) $display("FAIL simul_count: got %0d want 3", count); else passes++;
        checks++; if (in_ready !== 1'b1) $display("FAIL simul_in_ready: got %b want 1", in_ready); else passes++;
        checks++; if (out_pc !== 32'h3004) $display("FAIL simul_head: got %h want 00003004", out_pc); else passes++;
        cycle(1, 32'h3010, 32'h55, 0, 0, 0);
        checks++; if (count !== 3'd4) $display("FAIL simul_retry_count: got %0d want 4", count); else passes++;
        for (int k = 1; k < 5; k++) begin
            checks++; if (out_pc !== 32'h3000 + 4 * k)
                $display("FAIL simul_order: got %h want %h", out_pc, 32'h3000 + 4 * k); else passes++;
            cycle(0, 0, 0, 1, 0, 0);
        end
    endtask

    task automatic test_adel;
        logic [31:0] pcs [4];
        logic        want [4];
        pcs  = '{32'h3002, 32'h2ffc, 32'h7000, 32'h6ffc};
        want = '{1'b1, 1'b1, 1'b1, 1'b0};
        cycle(0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 4; k++) begin
            cycle(1, pcs[k], 32'hdead_beef, 1, 0, 0);
            checks++; if (out_pc !== pcs[k] || out_adel !== want[k] ||
                          out_instr !== (want[k] ? 32'h0 : 32'hdead_beef))
                $display("FAIL adel pc=%h: got pc=%h adel=%b instr=%h want adel=%b", pcs[k],
                         out_pc, out_adel, out_instr, want[k]); else passes++;
        end
    endtask

    task automatic test_flush;
        cycle(0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 3; k++) cycle(1, 32'h3000 + 4 * k, k, 0, 0, 0);
        in_valid = 1; in_pc = 32'h4000; out_ready = 1; flush = 1;
        #1;
        checks++; if (out_valid !== 1'b1 || count !== 3'd3 || out_pc !== 32'h3000)
            $display("FAIL flush_pre_state: got valid=%b count=%0d pc=%h want 1/3/00003000",
                     out_valid, count, out_pc); else passes++;
        cycle(1, 32'h4000, 32'h77, 1, 1, 0);
        checks++; if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL flush_post: got count=%0d valid=%b ready=%b want 0/0/1",
                     count, out_valid, in_ready); else passes++;
        cycle(1, 32'h4000, 32'h77, 0, 0, 0);
        checks++; if (count !== 3'd1 || out_pc !== 32'h4000)
            $display("FAIL flush_redirect_push: got count=%0d pc=%h want 1/00004000", count, out_pc); else passes++;
        cycle(1, 32'h4004, 32'h78, 0, 0, 0);
        cycle(1, 32'h4008, 32'h79, 0, 0, 0);
        cycle(1, 32'h400c, 32'h7a, 1, 1, 1);
        checks++; if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL reset_flush: got count=%0d valid=%b ready=%b want 0/0/1",
                     count, out_valid, in_ready); else passes++;
    endtask

    task automatic test_random;
        logic [31:0] pcv, e_pc, e_instr;
        logic        e_valid, e_adel;
        int          errs;
        cycle(0, 0, 0, 0, 0, 1);
        errs = 0;
        for (int n = 0; n < 400; n++) begin
            pcv = $urandom_range(32'h7010, 32'h2ff0);
            if ($urandom_range(0, 3) != 0) pcv[1:0] = 2'b00;
            cycle($urandom_range(0, 9) < 7, pcv, $urandom(), $urandom_range(0, 9) < 6,
                  $urandom_range(0, 24) == 0, $urandom_range(0, 99) == 0);
            e_valid = mq.size() != 0;
            e_pc    = e_valid ? mq[0].pc : 32'h0;
            e_instr = e_valid ? mq[0].instr : 32'h0;
            e_adel  = e_valid ? mq[0].adel : 1'b0;
            checks++;
            if (count !== 3'(mq.size()) || out_valid !== e_valid || in_ready !== (mq.size() != DEPTH) ||
                out_pc !== e_pc || out_instr !== e_instr || out_adel !== e_adel) begin
                if (errs < 10)
                    $display("FAIL random n=%0d: got cnt=%0d v=%b r=%b pc=%h in=%h ad=%b want cnt=%0d v=%b pc=%h in=%h ad=%b",
                             n, count, out_valid, in_ready, out_pc, out_instr, out_adel,
                             mq.size(), e_valid, e_pc, e_instr, e_adel);
                errs++;
            end else passes++;
        end
    endtask

    initial begin
        reset = 1; in_valid = 0; in_pc = 0; in_instr = 0; flush = 0; out_ready = 0;
        test_reset();
        test_fill();
        test_stream();
        test_full_simul();
        test_adel();
        test_flush();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/if_fetch_buffer.md
# if_fetch_buffer

Instruction fetch buffer between the PC/instruction-memory fetch stage and the decode stage of the pipelined MIPS core. Each cycle it captures a fetched `{pc, instr}` pair, tags it with an address-error flag, and holds it in a small FIFO until decode accepts it. Its not-full signal is the stall input for the PC register. A branch or jump redirect flushes the buffer in a single cycle.

## Interface
- `DEPTH`, 4: number of entries; power of two, ≥ 2.
- `PC_LO`, 32'h0000_3000: lowest legal fetch address.
- `PC_HI`, 32'h0000_6ffc: highest legal fetch address.

- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high; empties buffer.
- `in_valid`  in  1  fetch stage presents a fetched word this cycle.
- `in_pc`  in  32  address of the presented word.
- `in_instr`  in  32  instruction word read at `in_pc`.
- `in_ready`  out  1  buffer can accept; PC register holds its value when low.
- `flush`  in  1  redirect: discard all entries.
- `out_valid`  out  1  head entry valid.
- `out_pc`  out  32  head entry PC.
- `out_instr`  out  32  head entry instruction.
- `out_adel`  out  1  head entry has a fetch address error.
- `out_ready`  in  1  decode consumes the head entry this cycle.
- `count`  out  $clog2(DEPTH)+1  occupied entries, 0..DEPTH.

## Operation
- Storage: DEPTH entries of `{adel, pc[31:0], instr[31:0]}`, plus read pointer, write pointer (each $clog2(DEPTH) bits, wrap modulo DEPTH) and a count register.
- `in_ready` = (count != DEPTH). `out_valid` = (count != 0). Both are derived only from registered state; there is no combinational path from `out_ready` to `in_ready`.
- push = `in_valid & in_ready & ~flush`. pop = `out_valid & out_ready & ~flush`.
- Address check on push: `adel` = (`in_pc[1:0]` != 0) | (`in_pc` < PC_LO) | (`in_pc` > PC_HI), compared unsigned. When `adel`=1, the stored instr is forced to 32'h0000_0000 (nop) and the stored pc is `in_pc` unchanged.
- Push writes the entry at the write pointer, then increments the write pointer. Pop increments the read pointer. Push and pop in the same cycle: both pointers advance and count is unchanged.
- Full (count=DEPTH): `in_ready`=0, any `in_valid` is ignored, and pop is still allowed. After a pop from full, `in_ready`=1 in the next cycle.
- Empty (count=0): `out_valid`=0. There is no bypass: a pushed entry becomes visible the cycle after the push.
- Output values: when `out_valid`=1, `out_*` show the head entry. When `out_valid`=0, `out_pc`=0, `out_instr`=0 and `out_adel`=0.
- `flush`=1: the next state has both pointers 0 and count 0. Same-cycle `in_valid` and `out_ready` have no effect, and the outputs that cycle still reflect the pre-flush state.
- `reset` has priority over `flush` and over all traffic.
- Stored entries are not cleared on pop or flush. Only pointers and count change.

## Timing
- Reset (sync): the cycle after `reset` is sampled high, count=0, pointers=0, `in_ready`=1, `out_valid`=0, `out_pc`=0, `out_instr`=0, `out_adel`=0. Reset applied mid-stream discards all entries.
- Latency: push in cycle N gives `out_valid`=1 with that entry in cycle N+1 if the buffer was empty.
- Throughput: 1 push and 1 pop per cycle sustained when 0 < count < DEPTH.
- Handshake: an entry transfers on a cycle where valid and ready are both high at the edge. `in_valid` may drop without consequence. `out_*` are stable while `out_valid`=1 and `out_ready`=0.
- Wrap-around: after DEPTH pushes, the write pointer returns to 0. Order stays FIFO across the wrap.
- Flush in cycle N: `out_valid`=0 and `in_ready`=1 in cycle N+1. A fetch from the redirected PC may be pushed in cycle N+1.

## Test plan
- Reset/basic: assert reset for 2 cycles, then push pc=0x3000 instr=0x3c010001 with `out_ready`=0 → next cycle `out_valid`=1, `out_pc`=0x3000, `out_instr`=0x3c010001, `count`=1.
- Fill/full: push 0x3000, 0x3004, 0x3008, 0x300c with `out_ready`=0 → `count`=4 and `in_ready`=0. A fifth push of 0x3010 is ignored. Pop all four → order 0x3000..0x300c, then `out_valid`=0.
- Streaming wrap: `in_valid`=`out_ready`=1 for 10 cycles with pc 0x3000+4k → outputs are in order with 1-cycle lag, `count` holds at 1 after the first push, and no loss across pointer wrap.
- Simultaneous at full: with count=4, assert `out_ready`=1 and `in_valid`=1 → pop occurs, push is rejected (`in_ready` was 0), `count`=3. The next cycle the push is accepted.
- Address error: push pc=0x3002, then pc=0x2ffc, then pc=0x7000 → each entry has `out_adel`=1 and `out_instr`=0. Push pc=0x6ffc → `out_adel`=0.
- Flush/reset mid-operation: with count=3, assert `flush` together with `in_valid` and `out_ready` → next cycle `count`=0 and `out_valid`=0, with no entry consumed or added. Repeat with `reset` and `flush` high together → same result, reset has priority.
